// File: rtl/cacheline_adapter.sv
// Cache-line <-> burst-memory adapter: one whole-line request in, BEATS-beat burst out, one dfp_resp back.
// Optional build macro CLADAPT_FAST_RESP_EN drops the RESP state and answers combinationally on the last beat.
module cacheline_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [31:0]       bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  // state    | meaning
  // IDLE     | waiting for a request; write wins over read
  // WR_BURST | streaming write beats, low beat first
  // RD_REQ   | holding bmem_read until memory accepts it
  // RD_WAIT  | collecting read beats as rvalid arrives
  // RESP     | one-cycle dfp_resp pulse (absent with fast response)

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {IDLE, WR_BURST, RD_REQ, RD_WAIT, RESP} state_t;

`ifdef CLADAPT_FAST_RESP_EN
  localparam state_t DONE_ST = IDLE;
`else
  localparam state_t DONE_ST = RESP;
`endif

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       addr_q;
  logic              is_wr_q;
  logic [LINE_W-1:0] line_buf;
  logic              last_wr, last_rd;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^dfp_addr[OFF_W-1:0];
  assign last_wr = (state == WR_BURST) && bmem_ready && (cnt == LAST);
  assign last_rd = (state == RD_WAIT) && bmem_rvalid && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dfp_write)     state_nxt = WR_BURST;
        else if (dfp_read) state_nxt = RD_REQ;
      end
      WR_BURST: if (last_wr)    state_nxt = DONE_ST;
      RD_REQ:   if (bmem_ready) state_nxt = RD_WAIT;
      RD_WAIT:  if (last_rd)    state_nxt = DONE_ST;
      RESP:                     state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // The line buffer holds the write line during a write and collects beats during a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      addr_q   <= '0;
      is_wr_q  <= 1'b0;
      line_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (dfp_write || dfp_read) begin
            addr_q   <= {dfp_addr[31:OFF_W], OFF_W'(0)};
            is_wr_q  <= dfp_write;
            line_buf <= dfp_write ? dfp_wdata : '0;
          end
        end
        WR_BURST: if (bmem_ready) cnt <= cnt + CNT_W'(1);
        RD_WAIT: begin
          if (bmem_rvalid) begin
            line_buf[int'(cnt)*BEAT_W +: BEAT_W] <= bmem_rdata;
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dfp_resp   = 1'b0;
    dfp_rdata  = '0;
    bmem_addr  = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    case (state)
      WR_BURST: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = line_buf[int'(cnt)*BEAT_W +: BEAT_W];
`ifdef CLADAPT_FAST_RESP_EN
        dfp_resp   = last_wr;
`endif
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
      end
      RD_WAIT: begin
        bmem_addr = addr_q;
`ifdef CLADAPT_FAST_RESP_EN
        if (last_rd) begin
          dfp_resp  = 1'b1;
          dfp_rdata = {bmem_rdata, line_buf[LINE_W-BEAT_W-1:0]};
        end
`endif
      end
      RESP: begin
        dfp_resp  = 1'b1;
        dfp_rdata = is_wr_q ? '0 : line_buf;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed, cycle-exact bench for cacheline_adapter in its default build (registered RESP state).
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_cacheline_adapter;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       dfp_addr;
  logic              dfp_read, dfp_write;
  logic [LINE_W-1:0] dfp_wdata, dfp_rdata;
  logic              dfp_resp;
  logic [31:0]       bmem_addr;
  logic              bmem_read, bmem_write;
  logic [BEAT_W-1:0] bmem_wdata, bmem_rdata;
  logic              bmem_ready, bmem_rvalid;

  int pass_cnt = 0;
  int total_cnt = 0;
  int resp_cnt = 0;

  cacheline_adapter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .rst(rst),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_rdata(bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dfp_resp === 1'b1) resp_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dfp_write = 1'b1;
    tick(); tick();
    @(negedge clk);
    total_cnt++;
    if ({dfp_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata, dfp_rdata} !== '0)
      $display("FAIL reset_outputs: got resp=%b rd=%b wr=%b addr=%h want all zero", dfp_resp, bmem_read, bmem_write, bmem_addr);
    else pass_cnt++;
    tick();
    rst = 1'b0; dfp_write = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({dfp_resp, bmem_read, bmem_write, bmem_addr} !== '0)
      $display("FAIL post_reset_idle: got resp=%b rd=%b wr=%b addr=%h want all zero", dfp_resp, bmem_read, bmem_write, bmem_addr);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_write();
    logic [LINE_W-1:0] wd;
    int r0;
    wd = {64'h4444_0000_0000_0004, 64'h3333_0000_0000_0003, 64'h2222_0000_0000_0002, 64'h1111_0000_0000_0001};
    r0 = resp_cnt;
    dfp_addr = 32'h0000_1234; dfp_wdata = wd; dfp_write = 1'b1; bmem_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({bmem_write, bmem_read, bmem_addr, dfp_resp} !== {1'b1, 1'b0, 32'h0000_1220, 1'b0})
        $display("FAIL write_beat%0d_ctrl: got wr=%b rd=%b addr=%h resp=%b want wr=1 rd=0 addr=00001220 resp=0", i, bmem_write, bmem_read, bmem_addr, dfp_resp);
      else pass_cnt++;
      total_cnt++;
      if (bmem_wdata !== wd[i*BEAT_W +: BEAT_W])
        $display("FAIL write_beat%0d_data: got %h want %h", i, bmem_wdata, wd[i*BEAT_W +: BEAT_W]);
      else pass_cnt++;
      tick();
    end
    @(negedge clk);
    total_cnt++;
    if ({dfp_resp, bmem_write, dfp_rdata} !== {1'b1, 1'b0, 256'd0})
      $display("FAIL write_resp: got resp=%b wr=%b rdata=%h want resp=1 wr=0 rdata=0", dfp_resp, bmem_write, dfp_rdata);
    else pass_cnt++;
    tick();
    dfp_write = 1'b0;
    total_cnt++;
    if (resp_cnt - r0 !== 1) $display("FAIL write_resp_count: got %0d want 1", resp_cnt - r0);
    else pass_cnt++;
  endtask

  task automatic test_read();
    int r0;
    r0 = resp_cnt;
    dfp_addr = 32'h8000_00E0; dfp_read = 1'b1; bmem_ready = 1'b1;
    tick();
    @(negedge clk);
    total_cnt++;
    if ({bmem_read, bmem_write, bmem_addr} !== {1'b1, 1'b0, 32'h8000_00E0})
      $display("FAIL read_req: got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=800000e0", bmem_read, bmem_write, bmem_addr);
    else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++;
    if (bmem_read !== 1'b0) $display("FAIL read_req_single: got bmem_read=%b want 0", bmem_read);
    else pass_cnt++;
    repeat (4) tick();
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1; bmem_rdata = 64'hA + 64'(k);
      @(negedge clk);
      total_cnt++;
      if (dfp_resp !== 1'b0) $display("FAIL read_early_resp%0d: got %b want 0", k, dfp_resp);
      else pass_cnt++;
      tick();
    end
    bmem_rvalid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({dfp_resp, dfp_rdata} !== {1'b1, 64'hD, 64'hC, 64'hB, 64'hA})
      $display("FAIL read_resp: got resp=%b rdata=%h want resp=1 rdata=000000000000000d000000000000000c000000000000000b000000000000000a", dfp_resp, dfp_rdata);
    else pass_cnt++;
    tick();
    dfp_read = 1'b0;
    total_cnt++;
    if (resp_cnt - r0 !== 1) $display("FAIL read_resp_count: got %0d want 1", resp_cnt - r0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = resp_cnt;
    dfp_addr = 32'h0000_0040; dfp_wdata = {4{64'h5A5A_5A5A_0000_0040}}; dfp_write = 1'b1; bmem_ready = 1'b1;
    tick();
    repeat (4) tick();
    @(negedge clk);
    total_cnt++;
    if (dfp_resp !== 1'b1) $display("FAIL b2b_write_resp: got %b want 1", dfp_resp);
    else pass_cnt++;
    tick();
    dfp_write = 1'b0; dfp_read = 1'b1; dfp_addr = 32'h0000_0080;
    tick();
    @(negedge clk);
    total_cnt++;
    if ({bmem_read, bmem_addr} !== {1'b1, 32'h0000_0080})
      $display("FAIL b2b_read_accept: got rd=%b addr=%h want rd=1 addr=00000080", bmem_read, bmem_addr);
    else pass_cnt++;
    tick();
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1; bmem_rdata = 64'h11 + 64'(k);
      tick();
    end
    bmem_rvalid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({dfp_resp, dfp_rdata} !== {1'b1, 64'h14, 64'h13, 64'h12, 64'h11})
      $display("FAIL b2b_read_resp: got resp=%b rdata=%h", dfp_resp, dfp_rdata);
    else pass_cnt++;
    tick();
    dfp_read = 1'b0;
    total_cnt++;
    if (resp_cnt - r0 !== 2) $display("FAIL b2b_resp_count: got %0d want 2", resp_cnt - r0);
    else pass_cnt++;
  endtask

  task automatic test_ready_stall();
    int r0;
    r0 = resp_cnt;
    dfp_addr = 32'h0000_0100; dfp_wdata = {64'hBB03, 64'hBB02, 64'hBB01, 64'hBB00};
    dfp_write = 1'b1; bmem_ready = 1'b1;
    tick();
    @(negedge clk);
    total_cnt++;
    if (bmem_wdata !== 64'hBB00) $display("FAIL stall_beat0: got %h want bb00", bmem_wdata);
    else pass_cnt++;
    tick();
    tick();
    bmem_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      total_cnt++;
      if ({bmem_write, bmem_wdata} !== {1'b1, 64'hBB02})
        $display("FAIL stall_hold%0d: got wr=%b data=%h want wr=1 data=bb02", s, bmem_write, bmem_wdata);
      else pass_cnt++;
      tick();
    end
    bmem_ready = 1'b1;
    tick();
    @(negedge clk);
    total_cnt++;
    if (bmem_wdata !== 64'hBB03) $display("FAIL stall_beat3: got %h want bb03", bmem_wdata);
    else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++;
    if (dfp_resp !== 1'b1) $display("FAIL stall_write_resp: got %b want 1", dfp_resp);
    else pass_cnt++;
    tick();
    dfp_write = 1'b0;
    // Read request stalled; a stray rvalid during IDLE/RD_REQ must not be captured.
    dfp_addr = 32'h0000_0140; dfp_read = 1'b1; bmem_ready = 1'b0;
    bmem_rvalid = 1'b1; bmem_rdata = 64'hDEAD;
    tick();
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      total_cnt++;
      if (bmem_read !== 1'b1) $display("FAIL stall_rd_hold%0d: got %b want 1", s, bmem_read);
      else pass_cnt++;
      tick();
    end
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        bmem_rvalid = 1'b0;
        tick();
      end
      bmem_rvalid = 1'b1; bmem_rdata = 64'h21 + 64'(k);
      tick();
    end
    bmem_rvalid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({dfp_resp, dfp_rdata} !== {1'b1, 64'h24, 64'h23, 64'h22, 64'h21})
      $display("FAIL stall_read_resp: got resp=%b rdata=%h", dfp_resp, dfp_rdata);
    else pass_cnt++;
    tick();
    dfp_read = 1'b0;
    total_cnt++;
    if (resp_cnt - r0 !== 2) $display("FAIL stall_resp_count: got %0d want 2", resp_cnt - r0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int r0;
    r0 = resp_cnt;
    dfp_addr = 32'h0000_0200; dfp_read = 1'b1; bmem_ready = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      bmem_rvalid = 1'b1; bmem_rdata = 64'h31 + 64'(k);
      tick();
    end
    bmem_rvalid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bmem_addr !== 32'h0000_0200) $display("FAIL rstmid_active: got addr=%h want 00000200", bmem_addr);
    else pass_cnt++;
    tick();
    rst = 1'b1; dfp_read = 1'b0;
    tick();
    rst = 1'b0; bmem_rvalid = 1'b1; bmem_rdata = 64'h33;
    @(negedge clk);
    total_cnt++;
    if ({dfp_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata, dfp_rdata} !== '0)
      $display("FAIL rstmid_outputs: got resp=%b rd=%b wr=%b addr=%h want all zero", dfp_resp, bmem_read, bmem_write, bmem_addr);
    else pass_cnt++;
    tick();
    bmem_rdata = 64'h34;
    tick();
    bmem_rvalid = 1'b0;
    tick();
    total_cnt++;
    if (resp_cnt - r0 !== 0) $display("FAIL rstmid_no_resp: got %0d want 0", resp_cnt - r0);
    else pass_cnt++;
    dfp_addr = 32'h0000_0240; dfp_read = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1; bmem_rdata = 64'h41 + 64'(k);
      tick();
    end
    bmem_rvalid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({dfp_resp, dfp_rdata} !== {1'b1, 64'h44, 64'h43, 64'h42, 64'h41})
      $display("FAIL rstmid_new_read: got resp=%b rdata=%h", dfp_resp, dfp_rdata);
    else pass_cnt++;
    tick();
    dfp_read = 1'b0;
    total_cnt++;
    if (resp_cnt - r0 !== 1) $display("FAIL rstmid_resp_count: got %0d want 1", resp_cnt - r0);
    else pass_cnt++;
  endtask

  task automatic test_both();
    int r0;
    r0 = resp_cnt;
    dfp_addr = 32'h0000_041F; dfp_wdata = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
    dfp_read = 1'b1; dfp_write = 1'b1; bmem_ready = 1'b1;
    tick();
    @(negedge clk);
    total_cnt++;
    if ({bmem_write, bmem_read, bmem_addr, bmem_wdata} !== {1'b1, 1'b0, 32'h0000_0400, 64'hC0})
      $display("FAIL both_write_wins: got wr=%b rd=%b addr=%h data=%h want wr=1 rd=0 addr=00000400 data=c0", bmem_write, bmem_read, bmem_addr, bmem_wdata);
    else pass_cnt++;
    repeat (4) tick();
    @(negedge clk);
    total_cnt++;
    if ({dfp_resp, dfp_rdata} !== {1'b1, 256'd0})
      $display("FAIL both_resp_rdata: got resp=%b rdata=%h want resp=1 rdata=0", dfp_resp, dfp_rdata);
    else pass_cnt++;
    tick();
    dfp_read = 1'b0; dfp_write = 1'b0;
    total_cnt++;
    if (resp_cnt - r0 !== 1) $display("FAIL both_resp_count: got %0d want 1", resp_cnt - r0);
    else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_ready_stall();
    test_reset_mid();
    test_both();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
